axi_rd_responder: RTL and testbench
===================================

// Module: axi_rd_responder
// PURPOSE
// - AXI read-channel responder (slave) serving AR/R bursts from a word-wide synchronous SRAM.
// - Sits on the far side of the merged cache read port, as the memory model in SoC sims and as the on-chip boot-ROM/RAM reader.
// - Handles one outstanding burst at a time: one AR accepted, all beats returned, then the next AR.
// PARAMETERS
// - ID_W    4   width of arid/rid
// - LEN_W   8   width of arlen; beats per burst = arlen+1
// - MEM_AW  14  SRAM word-address width; valid byte range is [0, 4*2^MEM_AW)
// PORTS
// - clk          in   1      single clock; all logic on its rising edge
// - rst          in   1      reset, synchronous and active-high
// - arid         in   ID_W   read request ID
// - araddr       in   32     start byte address; bits [1:0] ignored
// - arlen        in   LEN_W  beats-1
// - arsize       in   3      only 3'b010 (4-byte) supported
// - arburst      in   2      00 FIXED, 01 INCR, 10 WRAP, 11 reserved
// - arvalid      in   1      AR valid
// - arready      out  1      AR ready
// - rid          out  ID_W   echo of the accepted arid
// - rdata        out  32     beat data
// - rresp        out  2      00 OKAY, 10 SLVERR
// - rlast        out  1      final beat of the burst
// - rvalid       out  1      R valid
// - rready       in   1      R ready from initiator
// - sram_en      out  1      SRAM read strobe
// - sram_addr    out  MEM_AW SRAM word address
// - sram_rdata   in   32     SRAM data, valid the cycle after sram_en
// BEHAVIOUR
// - Reset: state IDLE; arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=00, sram_en=0.
// - FSM states IDLE -> FETCH -> DATA -> (FETCH | IDLE).
// - IDLE: arready=1. On arvalid&arready, latch id, addr, len, burst, err; beat counter=0; go to FETCH.
// - FETCH: one cycle. sram_en=1 with sram_addr=cur_addr[MEM_AW+1:2], or sram_en=0 when err. Go to DATA.
// - DATA: rvalid=1; rdata=sram_rdata captured (32'h0 when err); rresp=err?10:00; rlast=(beat==len).
//   R outputs are held stable until rready.
// - rvalid&rready in DATA:
//   - rlast=1 -> IDLE, with rvalid=0 in the next cycle.
//   - rlast=0 -> beat+1, advance address, go to FETCH.
// - Timing: handshake in cycle T gives first rvalid in T+2. Throughput is 1 beat per 2 cycles with rready tied high.
// - Earliest next arready after the final handshake is in the following cycle.
// - Address advance:
//   - FIXED: no change.
//   - INCR: +4, 32-bit wrap-around at 2^32.
//   - Reserved (11): SLVERR for all beats.
// - err is fixed at AR acceptance and applies to every beat of the burst. It is set when:
//   - arsize != 3'b010, or
//   - the start address is >= 4*2^MEM_AW, or
//   - an INCR burst's last beat address passes the top of range.
// - Error bursts still return exactly arlen+1 beats with rlast on the final beat.
// - arlen=0: single beat, rlast=1 on the first beat.
// - Maximum arlen=2^LEN_W-1; the beat counter is LEN_W bits and never wraps within a burst.
// - Reset mid-burst: next cycle is IDLE, rvalid=0; the in-flight burst is abandoned with no further beats.
// - arvalid outside IDLE: ignored (arready=0), no state change.
// CONFIGURATION
// - AXI_RD_WRAP_EN defined:
//   - WRAP bursts are supported.
//   - arlen must be 1, 3, 7 or 15, else SLVERR.
//   - Container = (arlen+1)*4 bytes, aligned down from araddr.
//   - Address increments by 4 and wraps to the container base at its top.
// - AXI_RD_WRAP_EN undefined: WRAP (10) is treated exactly as reserved, i.e. SLVERR for all beats.
// TESTING
// - Reset 3 cycles, then idle -> arready=1, rvalid=0, sram_en=0.
// - SRAM[w]=w*0x11111111. AR INCR, araddr=0x40, arlen=3, arid=5, rready=1
//   -> rdata 0x10*0x11111111..0x13*0x11111111 (32-bit wrap), rid=5, rresp=00, rlast only on 4th beat.
// - Single beat, arlen=0, araddr=0x8, rready held low 5 cycles
//   -> rvalid=1, rdata=SRAM[2] stable throughout, rlast=1; back in IDLE after the handshake.
// - arsize=3'b001, arlen=1 -> 2 beats, rresp=10, rdata=0, sram_en never asserted.
// - WRAP, araddr=0x38, arlen=3:
//   - with AXI_RD_WRAP_EN -> word addresses 0xE,0xF,0xC,0xD, OKAY.
//   - without -> 4 beats of SLVERR.
// - Assert rst during beat 2 of an arlen=7 burst -> next cycle rvalid=0, arready=1; a new AR is served correctly.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI read-channel responder: serves one AR burst at a time from a word-wide synchronous SRAM.
// Optional WRAP burst support is compiled in when AXI_RD_WRAP_EN is defined.
module axi_rd_responder #(
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              sram_en,
  output logic [MEM_AW-1:0] sram_addr,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [32:0] BYTE_LIMIT = 33'((64'd1 << MEM_AW) * 4);
  localparam logic [31:0] WORD_MAX   = 32'((64'd1 << MEM_AW) - 1);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   id_reg;
  logic [31:0]       addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  beat_reg;
  logic [1:0]        burst_reg;
  logic              err_reg;
  logic              hold_reg;
  logic [31:0]       rdata_reg;

  logic              ar_hs;
  logic              r_hs;
  logic [31:0]       last_word;
  logic              size_err, start_err, incr_err, burst_err, ar_err;
  logic [31:0]       addr_inc;

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // Error classification is decided once, from the AR fields, and sticks for the whole burst.
  assign last_word = {2'b00, araddr[31:2]} + 32'(arlen);
  assign size_err  = (arsize != 3'b010);
  assign start_err = ({1'b0, araddr} >= BYTE_LIMIT);
  assign incr_err  = (arburst == 2'b01) && (last_word > WORD_MAX);

`ifdef AXI_RD_WRAP_EN
  logic wrap_len_ok;
  assign wrap_len_ok = (arlen == LEN_W'(1)) || (arlen == LEN_W'(3)) ||
                       (arlen == LEN_W'(7)) || (arlen == LEN_W'(15));
  assign burst_err   = (arburst == 2'b11) || ((arburst == 2'b10) && !wrap_len_ok);
`else
  assign burst_err   = arburst[1];
`endif

  assign ar_err   = size_err | start_err | incr_err | burst_err;
  assign addr_inc = addr_reg + 32'd4;

`ifdef AXI_RD_WRAP_EN
  // Container byte-offset mask is {len,2'b11} for power-of-two beat counts; bits above it stay put.
  logic [31:0] wrap_mask;
  logic [31:0] wrap_addr;
  assign wrap_mask = 32'({len_reg, 2'b11});
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_wrap
      assign wrap_addr[gi] = wrap_mask[gi] ? addr_inc[gi] : addr_reg[gi];
    end
  endgenerate
`endif

  always_comb begin
    addr_next = addr_reg;
    case (burst_reg)
      2'b01:   addr_next = addr_inc;
`ifdef AXI_RD_WRAP_EN
      2'b10:   addr_next = wrap_addr;
`endif
      default: addr_next = addr_reg;
    endcase
  end

  // State register and burst context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
      burst_reg <= 2'b00;
      err_reg   <= 1'b0;
      hold_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ar_hs) begin
        id_reg    <= arid;
        addr_reg  <= araddr;
        len_reg   <= arlen;
        beat_reg  <= '0;
        burst_reg <= arburst;
        err_reg   <= ar_err;
      end
      // SRAM output is only guaranteed for one cycle, so freeze it while the beat stalls.
      if (state_reg == DATA && !hold_reg) begin
        rdata_reg <= rdata;
        hold_reg  <= 1'b1;
      end
      if (r_hs) begin
        hold_reg <= 1'b0;
        if (!rlast) begin
          beat_reg <= beat_reg + 1'b1;
          addr_reg <= addr_next;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ar_hs) state_next = FETCH;
      FETCH:   state_next = DATA;
      DATA:    if (r_hs) state_next = rlast ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are masked during reset so nothing is offered while rst is high.
  always_comb begin
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    sram_en   = 1'b0;
    sram_addr = addr_reg[MEM_AW+1:2];
    rid       = id_reg;
    rdata     = rdata_reg;
    case (state_reg)
      IDLE: begin
        arready = !rst;
      end
      FETCH: begin
        sram_en = !rst && !err_reg;
      end
      DATA: begin
        rvalid = !rst;
        rlast  = (beat_reg == len_reg);
        rresp  = err_reg ? 2'b10 : 2'b00;
        if (!hold_reg) rdata = err_reg ? 32'h0 : sram_rdata;
      end
      default: begin
        arready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: a burst table plus hand sequences for stall and mid-burst reset.
// Expectations for the WRAP entry follow AXI_RD_WRAP_EN.
module tb_axi_rd_responder;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int MEM_AW = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              sram_en;
  logic [MEM_AW-1:0] sram_addr;
  logic [31:0]       sram_rdata;

  always #5 clk = ~clk;

  axi_rd_responder #(.ID_W(ID_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  // SRAM model: word w holds w*0x11111111, one-cycle read latency.
  int sram_en_cnt = 0;
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata  <= 32'(sram_addr) * 32'h11111111;
      sram_en_cnt <= sram_en_cnt + 1;
    end
  end

  function automatic logic [31:0] word_val(input logic [13:0] w);
    return 32'(w) * 32'h11111111;
  endfunction

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic             err;
    logic [3:0][13:0] w;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id, input logic err,
                              input logic [13:0] w0, input logic [13:0] w1,
                              input logic [13:0] w2, input logic [13:0] w3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id; v.err = err;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns the number of extra negedges before rvalid appeared (1 means 2-cycle spacing).
  task automatic wait_rvalid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!rvalid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int n;
    n = 0;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int cnt0;
    logic [31:0] exp_d;
    cnt0 = sram_en_cnt;
    issue_ar(v.addr, v.len, v.size, v.burst, v.id);
    for (int b = 0; b <= int'(v.len); b++) begin
      wait_rvalid(lat);
      exp_d = v.err ? 32'h0 : word_val(v.w[b]);
      chk($sformatf("v%0d_b%0d_latency", idx, b), 32'(lat), 32'd1);
      chk($sformatf("v%0d_b%0d_rid", idx, b), 32'(rid), 32'(v.id));
      chk($sformatf("v%0d_b%0d_rdata", idx, b), rdata, exp_d);
      chk($sformatf("v%0d_b%0d_rresp", idx, b), 32'(rresp), v.err ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_b%0d_rlast", idx, b), 32'(rlast), 32'(b == int'(v.len)));
      @(posedge clk);
    end
    @(negedge clk);
    chk($sformatf("v%0d_end_rvalid", idx), 32'(rvalid), 32'd0);
    chk($sformatf("v%0d_end_arready", idx), 32'(arready), 32'd1);
    chk($sformatf("v%0d_sram_reads", idx), 32'(sram_en_cnt - cnt0), v.err ? 32'd0 : 32'(v.len) + 32'd1);
    $display("burst %0d: id=%0h addr=%08h len=%0d burst=%0b size=%0b err=%0b done",
             idx, v.id, v.addr, v.len, v.burst, v.size, v.err);
  endtask

  vec_t vecs[9];
  logic wrap_err;

  initial begin
    int lat;
`ifdef AXI_RD_WRAP_EN
    wrap_err = 1'b0;
`else
    wrap_err = 1'b1;
`endif
    vecs[0] = mk(32'h40,    8'd3, 3'b010, 2'b01, 4'h5, 1'b0, 14'h10, 14'h11, 14'h12, 14'h13);
    vecs[1] = mk(32'h20,    8'd2, 3'b010, 2'b00, 4'h3, 1'b0, 14'h8,  14'h8,  14'h8,  14'h0);
    vecs[2] = mk(32'h0,     8'd1, 3'b001, 2'b01, 4'h1, 1'b1, 14'h0,  14'h0,  14'h0,  14'h0);
    vecs[3] = mk(32'h38,    8'd3, 3'b010, 2'b10, 4'h7, wrap_err, 14'hE, 14'hF, 14'hC, 14'hD);
    vecs[4] = mk(32'h10000, 8'd0, 3'b010, 2'b01, 4'h2, 1'b1, 14'h0,  14'h0,  14'h0,  14'h0);
    vecs[5] = mk(32'hFFF8,  8'd1, 3'b010, 2'b01, 4'h4, 1'b0, 14'h3FFE, 14'h3FFF, 14'h0, 14'h0);
    vecs[6] = mk(32'hFFFC,  8'd1, 3'b010, 2'b01, 4'h8, 1'b1, 14'h0,  14'h0,  14'h0,  14'h0);
    vecs[7] = mk(32'h0,     8'd0, 3'b010, 2'b11, 4'hF, 1'b1, 14'h0,  14'h0,  14'h0,  14'h0);
    vecs[8] = mk(32'h0,     8'd2, 3'b010, 2'b10, 4'hA, 1'b1, 14'h0,  14'h0,  14'h0,  14'h0);

    rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'b010;
    arburst = 2'b01; rready = 1'b1; sram_rdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_sram_en", 32'(sram_en), 32'd0);
    $display("reset sequence done");

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Single beat held under rready=0; a competing AR must be refused meanwhile.
    rready = 1'b0;
    issue_ar(32'h8, 8'd0, 3'b010, 2'b01, 4'h9);
    wait_rvalid(lat);
    chk("stall_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      arvalid = 1'b1; arid = 4'h2; araddr = 32'h100; arlen = 8'd0;
      chk($sformatf("stall_rvalid_%0d", i), 32'(rvalid), 32'd1);
      chk($sformatf("stall_rdata_%0d", i), rdata, 32'h22222222);
      chk($sformatf("stall_rlast_%0d", i), 32'(rlast), 32'd1);
      chk($sformatf("stall_rid_%0d", i), 32'(rid), 32'h9);
      chk($sformatf("stall_arready_%0d", i), 32'(arready), 32'd0);
      @(negedge clk);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_end_rvalid", 32'(rvalid), 32'd0);
    chk("stall_end_arready", 32'(arready), 32'd1);
    chk("stall_end_rid", 32'(rid), 32'h9);
    $display("stall burst: id=9 addr=00000008 len=0 held 5 cycles done");

    // Reset while beat 2 of an 8-beat burst is on the bus.
    issue_ar(32'h0, 8'd7, 3'b010, 2'b01, 4'h6);
    wait_rvalid(lat);
    chk("mid_b0_rdata", rdata, 32'h0);
    @(posedge clk);
    wait_rvalid(lat);
    chk("mid_b1_rdata", rdata, 32'h11111111);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_quiet_%0d", i), 32'(rvalid), 32'd0);
    end
    $display("mid-burst reset: id=6 len=7 abandoned after beat 2");
    run_vec(9, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
